// File: rtl/writeback_regfile.sv
// Purpose : writeback stage; decodes rd from the retiring instruction and commits dataC
//           into a 32-entry register file, with two bypassed combinational read ports.
// Latency : 1 cycle from Mem->Writeback register outputs to architectural state; reads are combinational.
// Backpressure: none; every valid cycle retires exactly one instruction.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   valid_in                        live instruction present this cycle
//   instruction_in/progcounter_in   retiring instruction and its PC
//   dataC_in                        result to commit
//   rs_addr/rt_addr                 read addresses, dataA_out/dataB_out read data
//   wb_en_out/wb_addr_out           commit strobe and destination (for hazard logic)
//   last_pc_out                     PC of most recent retired instruction
//   retired_count_out               retired count (only with WB_RETIRE_COUNTER_EN)
// Optional feature macro: WB_RETIRE_COUNTER_EN
module writeback_regfile #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [WIDTH-1:0]  instruction_in,
    input  logic [WIDTH-3:0]  progcounter_in,
    input  logic [WIDTH-1:0]  dataC_in,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [WIDTH-1:0]  dataA_out,
    output logic [WIDTH-1:0]  dataB_out,
    output logic              wb_en_out,
    output logic [ADDR_W-1:0] wb_addr_out,
    output logic [WIDTH-3:0]  last_pc_out
`ifdef WB_RETIRE_COUNTER_EN
    ,
    output logic [CNT_W-1:0]  retired_count_out
`endif
);

    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic              writing_class;

    logic [WIDTH-1:0]  regs_q [NUM_REGS];
    logic [WIDTH-3:0]  last_pc_q;
    logic [WIDTH-3:0]  last_pc_d;

    // Instruction bits below rd carry no meaning for this stage.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction_in[WIDTH-7-ADDR_W:0];

    assign opcode        = instruction_in[WIDTH-1:WIDTH-6];
    assign rd            = instruction_in[WIDTH-7:WIDTH-7-ADDR_W+1];
    // opcode[5]=1 is stores/branches, opcode 0 is NOP; neither writes.
    assign writing_class = !opcode[5] && (opcode != 6'd0);

    // Gated by rst_n so that nothing commits or bypasses while reset is held.
    assign wb_en_out   = rst_n && valid_in && writing_class && (rd != '0);
    assign wb_addr_out = rd;

    // Address 0 is forced to zero; the bypass also covers a same-cycle commit.
    always_comb begin
        dataA_out = '0;
        if (rst_n && (rs_addr != '0)) begin
            if (wb_en_out && (rs_addr == rd)) dataA_out = dataC_in;
            else                              dataA_out = regs_q[rs_addr];
        end
    end

    always_comb begin
        dataB_out = '0;
        if (rst_n && (rt_addr != '0)) begin
            if (wb_en_out && (rt_addr == rd)) dataB_out = dataC_in;
            else                              dataB_out = regs_q[rt_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (wb_en_out) begin
            regs_q[rd] <= dataC_in;
        end
    end

    always_comb begin
        last_pc_d = last_pc_q;
        if (valid_in) last_pc_d = progcounter_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_pc_q <= '0;
        else        last_pc_q <= last_pc_d;
    end

    assign last_pc_out = last_pc_q;

`ifdef WB_RETIRE_COUNTER_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Free-running modulo-2^CNT_W count of retired instructions.
    always_comb begin
        cnt_d = cnt_q;
        if (valid_in) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign retired_count_out = cnt_q;
`else
    localparam int UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic [WIDTH-1:0]  instruction_in;
    logic [WIDTH-3:0]  progcounter_in;
    logic [WIDTH-1:0]  dataC_in;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [WIDTH-1:0]  dataA_out;
    logic [WIDTH-1:0]  dataB_out;
    logic              wb_en_out;
    logic [ADDR_W-1:0] wb_addr_out;
    logic [WIDTH-3:0]  last_pc_out;
`ifdef WB_RETIRE_COUNTER_EN
    logic [CNT_W-1:0]  retired_count_out;
`endif

    int checks = 0;
    int errors = 0;

    writeback_regfile #(.WIDTH(WIDTH), .NUM_REGS(32), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .valid_in          (valid_in),
        .instruction_in    (instruction_in),
        .progcounter_in    (progcounter_in),
        .dataC_in          (dataC_in),
        .rs_addr           (rs_addr),
        .rt_addr           (rt_addr),
        .dataA_out         (dataA_out),
        .dataB_out         (dataB_out),
        .wb_en_out         (wb_en_out),
        .wb_addr_out       (wb_addr_out),
        .last_pc_out       (last_pc_out)
`ifdef WB_RETIRE_COUNTER_EN
        ,
        .retired_count_out (retired_count_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mk(input logic [5:0] op, input logic [4:0] rd);
        return {op, rd, 21'h0};
    endfunction

    // Advance past the next rising edge; leaves time 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rd,
                         input logic [31:0] d, input logic [29:0] pc);
        valid_in       = v;
        instruction_in = mk(op, rd);
        dataC_in       = d;
        progcounter_in = pc;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        valid_in = 1'b0; instruction_in = '0; progcounter_in = '0; dataC_in = '0;
        rs_addr = '0; rt_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); rt_addr = 5'(31 - a);
            #1;
            checks++;
            if (dataA_out !== 32'h0) begin
                errors++; $display("FAIL reset_readA addr=%0d got=%h exp=0", a, dataA_out);
            end
            checks++;
            if (dataB_out !== 32'h0) begin
                errors++; $display("FAIL reset_readB addr=%0d got=%h exp=0", 31 - a, dataB_out);
            end
        end
        checks++;
        if (last_pc_out !== 30'h0) begin
            errors++; $display("FAIL reset_last_pc got=%h exp=0", last_pc_out);
        end
`ifdef WB_RETIRE_COUNTER_EN
        checks++;
        if (retired_count_out !== 4'd0) begin
            errors++; $display("FAIL reset_count got=%0d exp=0", retired_count_out);
        end
`endif
    endtask

    task automatic test_write_bypass();
        rs_addr = 5'd7; rt_addr = 5'd7;
        drive(1'b1, 6'h01, 5'd7, 32'hDEADBEEF, 30'h10);
        checks++;
        if (wb_en_out !== 1'b1) begin errors++; $display("FAIL wb_en_r7 got=%b exp=1", wb_en_out); end
        checks++;
        if (wb_addr_out !== 5'd7) begin errors++; $display("FAIL wb_addr_r7 got=%0d exp=7", wb_addr_out); end
        checks++;
        if (dataA_out !== 32'hDEADBEEF) begin errors++; $display("FAIL bypassA got=%h exp=deadbeef", dataA_out); end
        checks++;
        if (dataB_out !== 32'hDEADBEEF) begin errors++; $display("FAIL bypassB got=%h exp=deadbeef", dataB_out); end
        tick();
        drive(1'b0, 6'h01, 5'd7, 32'h0, 30'h11);
        checks++;
        if (wb_en_out !== 1'b0) begin errors++; $display("FAIL wb_en_invalid got=%b exp=0", wb_en_out); end
        checks++;
        if (dataA_out !== 32'hDEADBEEF) begin errors++; $display("FAIL arrayA_r7 got=%h exp=deadbeef", dataA_out); end
        checks++;
        if (last_pc_out !== 30'h10) begin errors++; $display("FAIL last_pc_r7 got=%h exp=10", last_pc_out); end
        tick();
    endtask

    task automatic test_rd_zero();
        rs_addr = 5'd0; rt_addr = 5'd0;
        drive(1'b1, 6'h01, 5'd0, 32'h12345678, 30'h20);
        checks++;
        if (wb_en_out !== 1'b0) begin errors++; $display("FAIL wb_en_rd0 got=%b exp=0", wb_en_out); end
        checks++;
        if (dataA_out !== 32'h0) begin errors++; $display("FAIL rd0_bypass got=%h exp=0", dataA_out); end
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'h0, 30'h21);
        checks++;
        if (dataA_out !== 32'h0) begin errors++; $display("FAIL rd0_read got=%h exp=0", dataA_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        rs_addr = 5'd8; rt_addr = 5'd9;
        drive(1'b1, 6'h02, 5'd8, 32'h11110008, 30'h30);
        tick();
        drive(1'b1, 6'h1F, 5'd9, 32'h22220009, 30'h31);
        checks++;
        if (dataA_out !== 32'h11110008) begin errors++; $display("FAIL b2b_r8 got=%h exp=11110008", dataA_out); end
        checks++;
        if (dataB_out !== 32'h22220009) begin errors++; $display("FAIL b2b_r9_bypass got=%h exp=22220009", dataB_out); end
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'h0, 30'h0);
        checks++;
        if (dataB_out !== 32'h22220009) begin errors++; $display("FAIL b2b_r9 got=%h exp=22220009", dataB_out); end
        checks++;
        if (last_pc_out !== 30'h31) begin errors++; $display("FAIL b2b_last_pc got=%h exp=31", last_pc_out); end
    endtask

    task automatic test_non_writing();
`ifdef WB_RETIRE_COUNTER_EN
        logic [CNT_W-1:0] c0;
        c0 = retired_count_out;
`endif
        rs_addr = 5'd3; rt_addr = 5'd3;
        drive(1'b1, 6'h2B, 5'd3, 32'h0000FFFF, 30'h100);
        checks++;
        if (wb_en_out !== 1'b0) begin errors++; $display("FAIL wb_en_store got=%b exp=0", wb_en_out); end
        checks++;
        if (wb_addr_out !== 5'd3) begin errors++; $display("FAIL wb_addr_store got=%0d exp=3", wb_addr_out); end
        tick();
        checks++;
        if (last_pc_out !== 30'h100) begin errors++; $display("FAIL last_pc_store got=%h exp=100", last_pc_out); end
        drive(1'b1, 6'h00, 5'd3, 32'h0000FFFF, 30'h104);
        checks++;
        if (wb_en_out !== 1'b0) begin errors++; $display("FAIL wb_en_nop got=%b exp=0", wb_en_out); end
        tick();
        checks++;
        if (last_pc_out !== 30'h104) begin errors++; $display("FAIL last_pc_nop got=%h exp=104", last_pc_out); end
        drive(1'b0, 6'h01, 5'd3, 32'h0000FFFF, 30'h108);
        tick();
        checks++;
        if (last_pc_out !== 30'h104) begin errors++; $display("FAIL last_pc_hold got=%h exp=104", last_pc_out); end
        checks++;
        if (dataA_out !== 32'h0) begin errors++; $display("FAIL reg3_unchanged got=%h exp=0", dataA_out); end
`ifdef WB_RETIRE_COUNTER_EN
        checks++;
        if (retired_count_out !== CNT_W'(c0 + 4'd2)) begin
            errors++; $display("FAIL count_plus2 got=%0d exp=%0d", retired_count_out, CNT_W'(c0 + 4'd2));
        end
`endif
    endtask

    task automatic test_reset_pulse();
        rs_addr = 5'd5; rt_addr = 5'd6;
        drive(1'b1, 6'h01, 5'd5, 32'hA5A5A5A5, 30'h200);
        tick();
        drive(1'b0, 6'h00, 5'd0, 32'h0, 30'h0);
        checks++;
        if (dataA_out !== 32'hA5A5A5A5) begin errors++; $display("FAIL reg5_written got=%h exp=a5a5a5a5", dataA_out); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dataA_out !== 32'h0) begin errors++; $display("FAIL reg5_async_reset got=%h exp=0", dataA_out); end
        // Commit attempted across a rising edge while reset is held.
        drive(1'b1, 6'h01, 5'd6, 32'h66666666, 30'h300);
        checks++;
        if (wb_en_out !== 1'b0) begin errors++; $display("FAIL wb_en_in_reset got=%b exp=0", wb_en_out); end
        checks++;
        if (dataB_out !== 32'h0) begin errors++; $display("FAIL read_in_reset got=%h exp=0", dataB_out); end
        tick();
        @(negedge clk);
        drive(1'b0, 6'h00, 5'd0, 32'h0, 30'h0);
        rst_n = 1'b1;
        #1;
        checks++;
        if (dataB_out !== 32'h0) begin errors++; $display("FAIL reg6_no_commit got=%h exp=0", dataB_out); end
        checks++;
        if (last_pc_out !== 30'h0) begin errors++; $display("FAIL last_pc_in_reset got=%h exp=0", last_pc_out); end
        tick();
    endtask

`ifdef WB_RETIRE_COUNTER_EN
    task automatic test_counter_wrap();
        rst_n = 1'b0;
        drive(1'b0, 6'h00, 5'd0, 32'h0, 30'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, (i % 2 == 0) ? 6'h00 : 6'h2B, 5'd1, 32'h0, 30'(i));
            tick();
        end
        drive(1'b0, 6'h00, 5'd0, 32'h0, 30'h0);
        tick();
        checks++;
        if (retired_count_out !== 4'd1) begin errors++; $display("FAIL count_wrap got=%0d exp=1", retired_count_out); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_bypass();
        test_rd_zero();
        test_back_to_back();
        test_non_writing();
        test_reset_pulse();
`ifdef WB_RETIRE_COUNTER_EN
        test_counter_wrap();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
